// File: rtl/riscv_dmem_arb.sv
// riscv_dmem_arb: shares the single-port data memory between the CPU memory
// stage (port 0) and an external loader/debug master (port 1). One owner at a
// time, round-robin on ties, bounded burst while the other port is waiting,
// registered read return with a one-cycle valid pulse per accepted read.
module riscv_dmem_arb #(
  parameter int XLEN      = 32,
  parameter int BURST_MAX = 8
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  // port 0: CPU memory stage
  input  logic            i_m0_req,
  input  logic [XLEN-1:0] i_m0_addr,
  input  logic            i_m0_wr_en,
  input  logic [3:0]      i_m0_strb,
  input  logic [XLEN-1:0] i_m0_wr_data,
  output logic            o_m0_gnt,
  output logic [XLEN-1:0] o_m0_rd_data,
  output logic            o_m0_rvalid,
  // port 1: loader/debug master
  input  logic            i_m1_req,
  input  logic [XLEN-1:0] i_m1_addr,
  input  logic            i_m1_wr_en,
  input  logic [3:0]      i_m1_strb,
  input  logic [XLEN-1:0] i_m1_wr_data,
  output logic            o_m1_gnt,
  output logic [XLEN-1:0] o_m1_rd_data,
  output logic            o_m1_rvalid,
  // memory side
  output logic [XLEN-1:0] o_dmem_addr,
  output logic            o_dmem_wr_en,
  output logic [3:0]      o_dmem_strb,
  output logic [XLEN-1:0] o_dmem_wr_data,
  input  logic [XLEN-1:0] i_dmem_rd_data
);

  localparam int            BW   = $clog2(BURST_MAX) + 1;
  localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            last, last_nxt;
  logic [BW-1:0]   beats, beats_nxt, beats_acc;
  logic            rd_acc0, rd_acc1;

  logic            rvalid0_p1, rvalid1_p1;
  logic [XLEN-1:0] rd_data0_p1, rd_data1_p1;

  // Beat counter only needs to reach BURST_MAX; holding there lets an
  // unopposed owner burst forever without wrapping back below the limit.
  function automatic logic [BW-1:0] beats_sat(input logic [BW-1:0] b);
    return (b >= BMAX) ? BMAX : b + BW'(1);
  endfunction

  // Arbitration state, tie-break history and burst count.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      last  <= 1'b1;
      beats <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      beats <= beats_nxt;
    end
  end

  // Next-state decode, grants and memory-side mux of the owning port.
  always_comb begin
    state_nxt      = state;
    last_nxt       = last;
    beats_nxt      = beats;
    beats_acc      = beats;
    o_m0_gnt       = 1'b0;
    o_m1_gnt       = 1'b0;
    o_dmem_addr    = '0;
    o_dmem_wr_en   = 1'b0;
    o_dmem_strb    = '0;
    o_dmem_wr_data = '0;
    rd_acc0        = 1'b0;
    rd_acc1        = 1'b0;

    case (state)
      IDLE: begin
        if (i_m0_req && i_m1_req) state_nxt = last ? OWN0 : OWN1;
        else if (i_m0_req)        state_nxt = OWN0;
        else if (i_m1_req)        state_nxt = OWN1;
      end

      OWN0: begin
        o_m0_gnt    = 1'b1;
        // address follows the owner even when it is not requesting
        o_dmem_addr = i_m0_addr;
        if (i_m0_req) begin
          o_dmem_wr_en   = i_m0_wr_en;
          o_dmem_strb    = i_m0_strb;
          o_dmem_wr_data = i_m0_wr_data;
          rd_acc0        = ~i_m0_wr_en;
          beats_acc      = beats_sat(beats);
        end
        if (!i_m0_req) begin
          state_nxt = i_m1_req ? OWN1 : IDLE;
          last_nxt  = 1'b0;
          beats_nxt = '0;
        end else if (i_m1_req && (beats_acc == BMAX)) begin
          state_nxt = OWN1;
          last_nxt  = 1'b0;
          beats_nxt = '0;
        end else begin
          beats_nxt = beats_acc;
        end
      end

      OWN1: begin
        o_m1_gnt    = 1'b1;
        o_dmem_addr = i_m1_addr;
        if (i_m1_req) begin
          o_dmem_wr_en   = i_m1_wr_en;
          o_dmem_strb    = i_m1_strb;
          o_dmem_wr_data = i_m1_wr_data;
          rd_acc1        = ~i_m1_wr_en;
          beats_acc      = beats_sat(beats);
        end
        if (!i_m1_req) begin
          state_nxt = i_m0_req ? OWN0 : IDLE;
          last_nxt  = 1'b1;
          beats_nxt = '0;
        end else if (i_m0_req && (beats_acc == BMAX)) begin
          state_nxt = OWN0;
          last_nxt  = 1'b1;
          beats_nxt = '0;
        end else begin
          beats_nxt = beats_acc;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---- read return stage: capture memory data one edge after acceptance ----
  // Read data is cleared on reset so every output starts at zero.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rvalid0_p1  <= 1'b0;
      rvalid1_p1  <= 1'b0;
      rd_data0_p1 <= '0;
      rd_data1_p1 <= '0;
    end else begin
      rvalid0_p1 <= rd_acc0;
      rvalid1_p1 <= rd_acc1;
      if (rd_acc0) rd_data0_p1 <= i_dmem_rd_data;
      if (rd_acc1) rd_data1_p1 <= i_dmem_rd_data;
    end
  end

  assign o_m0_rvalid  = rvalid0_p1;
  assign o_m1_rvalid  = rvalid1_p1;
  assign o_m0_rd_data = rd_data0_p1;
  assign o_m1_rd_data = rd_data1_p1;

endmodule

// File: tb/tb_riscv_dmem_arb.sv
// Directed bench for riscv_dmem_arb with a small byte-strobed memory model.
module tb_riscv_dmem_arb;

  logic        clk;
  logic        rstn;
  logic        m0_req, m0_wr_en, m1_req, m1_wr_en;
  logic [31:0] m0_addr, m0_wr_data, m1_addr, m1_wr_data;
  logic [3:0]  m0_strb, m1_strb;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic [31:0] dmem_addr, dmem_wr_data, dmem_rd_data;
  logic        dmem_wr_en;
  logic [3:0]  dmem_strb;

  int total = 0;
  int bad   = 0;

  riscv_dmem_arb #(.XLEN(32), .BURST_MAX(8)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wr_en(m0_wr_en),
    .i_m0_strb(m0_strb), .i_m0_wr_data(m0_wr_data),
    .o_m0_gnt(m0_gnt), .o_m0_rd_data(m0_rd_data), .o_m0_rvalid(m0_rvalid),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wr_en(m1_wr_en),
    .i_m1_strb(m1_strb), .i_m1_wr_data(m1_wr_data),
    .o_m1_gnt(m1_gnt), .o_m1_rd_data(m1_rd_data), .o_m1_rvalid(m1_rvalid),
    .o_dmem_addr(dmem_addr), .o_dmem_wr_en(dmem_wr_en), .o_dmem_strb(dmem_strb),
    .o_dmem_wr_data(dmem_wr_data), .i_dmem_rd_data(dmem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, strobed write on rising edge
  logic [31:0] mem [0:63];
  assign dmem_rd_data = mem[dmem_addr[7:2]];
  always @(posedge clk) begin
    if (dmem_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (dmem_strb[b]) mem[dmem_addr[7:2]][8*b +: 8] <= dmem_wr_data[8*b +: 8];
    end
  end

  task automatic idle_inputs();
    m0_req = 0; m0_wr_en = 0; m0_addr = 0; m0_strb = 0; m0_wr_data = 0;
    m1_req = 0; m1_wr_en = 0; m1_addr = 0; m1_strb = 0; m1_wr_data = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rstn = 0;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1;
  endtask

  task automatic test_reset();
    rstn = 0;
    idle_inputs();
    m0_req = 1; m0_wr_en = 1; m0_addr = 32'h44; m0_strb = 4'hF; m0_wr_data = 32'h1234;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dmem_wr_en} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dmem_wr_en});
    end
    total++;
    if (dmem_addr !== 32'h0 || dmem_wr_data !== 32'h0 || dmem_strb !== 4'h0) begin
      bad++; $display("FAIL reset_dmem got addr=%h data=%h strb=%h exp=0", dmem_addr, dmem_wr_data, dmem_strb);
    end
    total++;
    if (m0_rd_data !== 32'h0 || m1_rd_data !== 32'h0) begin
      bad++; $display("FAIL reset_rd_data got=%h/%h exp=0", m0_rd_data, m1_rd_data);
    end
    @(posedge clk); #1;
    idle_inputs();
    rstn = 1;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    m0_req = 1; m0_wr_en = 1; m0_addr = 32'h10; m0_wr_data = 32'hDEADBEEF; m0_strb = 4'hF;
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b0 || dmem_wr_en !== 1'b0) begin
      bad++; $display("FAIL single_idle_cycle got gnt=%b we=%b exp=0/0", m0_gnt, dmem_wr_en);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      bad++; $display("FAIL single_gnt got=%b%b exp=10", m0_gnt, m1_gnt);
    end
    total++;
    if (dmem_wr_en !== 1'b1 || dmem_addr !== 32'h10 || dmem_wr_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_wr_mux got we=%b addr=%h data=%h exp=1/10/deadbeef", dmem_wr_en, dmem_addr, dmem_wr_data);
    end
    @(posedge clk); #1;
    m0_wr_en = 0;
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1 || m0_rvalid !== 1'b0) begin
      bad++; $display("FAIL single_rd_cycle got gnt=%b rvalid=%b exp=1/0", m0_gnt, m0_rvalid);
    end
    @(posedge clk); #1;
    m0_req = 0;
    @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b1 || m0_rd_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_rdata got v=%b d=%h exp=1/deadbeef", m0_rvalid, m0_rd_data);
    end
    total++;
    if (m1_gnt !== 1'b0 || dmem_wr_en !== 1'b0 || dmem_addr !== 32'h10) begin
      bad++; $display("FAIL single_drop got g1=%b we=%b addr=%h exp=0/0/10", m1_gnt, dmem_wr_en, dmem_addr);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0) begin
      bad++; $display("FAIL single_end got v=%b g=%b exp=0/0", m0_rvalid, m0_gnt);
    end
  endtask

  task automatic test_tie();
    do_reset();
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      bad++; $display("FAIL tie_idle got=%b%b exp=00", m0_gnt, m1_gnt);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || dmem_addr !== 32'h10) begin
      bad++; $display("FAIL tie_first got=%b%b addr=%h exp=10/10", m0_gnt, m1_gnt, dmem_addr);
    end
    @(posedge clk); #1;
    m0_req = 0;
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || m0_rvalid !== 1'b1) begin
      bad++; $display("FAIL tie_drop got=%b%b v=%b exp=10/1", m0_gnt, m1_gnt, m0_rvalid);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1 || dmem_addr !== 32'h20) begin
      bad++; $display("FAIL tie_handover got=%b%b addr=%h exp=01/20", m0_gnt, m1_gnt, dmem_addr);
    end
    @(posedge clk); #1;
    m1_req = 0;
    @(negedge clk);
    total++;
    if (m1_rvalid !== 1'b1) begin
      bad++; $display("FAIL tie_m1_rvalid got=%b exp=1", m1_rvalid);
    end
    @(posedge clk);
  endtask

  task automatic test_burst_limit();
    logic exp0;
    do_reset();
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      exp0 = ((i / 8) % 2) == 0;
      total++;
      if (m0_gnt !== exp0 || m1_gnt !== ~exp0) begin
        bad++; $display("FAIL burst_owner cycle=%0d got=%b%b exp=%b%b", i + 1, m0_gnt, m1_gnt, exp0, ~exp0);
      end
      @(posedge clk);
    end
    #1;
    idle_inputs();
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    m0_req = 1; m0_wr_en = 1; m0_strb = 4'hF; m0_addr = 32'h40; m0_wr_data = 32'hA5000000;
    @(posedge clk);
    for (int j = 0; j < 20; j++) begin
      #1;
      m0_addr = 32'h40 + 32'(4 * j);
      m0_wr_data = 32'hA5000000 + 32'(j);
      @(negedge clk);
      total++;
      if (m0_gnt !== 1'b1 || dmem_wr_en !== 1'b1) begin
        bad++; $display("FAIL b2b_write beat=%0d got g=%b we=%b exp=1/1", j, m0_gnt, dmem_wr_en);
      end
      @(posedge clk);
    end
    #1;
    m0_req = 0; m0_wr_en = 0;
    @(posedge clk); #1;
    m0_req = 1; m0_addr = 32'h40;
    @(posedge clk);
    for (int j = 0; j < 20; j++) begin
      #1;
      m0_addr = 32'h40 + 32'(4 * j);
      @(negedge clk);
      total++;
      if (m0_gnt !== 1'b1 || m0_rvalid !== (j > 0)) begin
        bad++; $display("FAIL b2b_read beat=%0d got g=%b v=%b exp=1/%b", j, m0_gnt, m0_rvalid, (j > 0));
      end
      if (j > 0) begin
        total++;
        if (m0_rd_data !== 32'hA5000000 + 32'(j - 1)) begin
          bad++; $display("FAIL b2b_rdata beat=%0d got=%h exp=%h", j - 1, m0_rd_data, 32'hA5000000 + 32'(j - 1));
        end
      end
      @(posedge clk);
    end
    #1;
    m0_req = 0;
    @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b1 || m0_rd_data !== 32'hA5000013) begin
      bad++; $display("FAIL b2b_last got v=%b d=%h exp=1/a5000013", m0_rvalid, m0_rd_data);
    end
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_strobe();
    @(posedge clk); #1;
    m1_req = 1; m1_wr_en = 1; m1_strb = 4'hF; m1_wr_data = 32'hFFFFFFFF; m1_addr = 32'hC0;
    @(negedge clk);
    total++;
    if (m1_gnt !== 1'b0 || dmem_wr_en !== 1'b0) begin
      bad++; $display("FAIL strb_idle got g=%b we=%b exp=0/0", m1_gnt, dmem_wr_en);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (m1_gnt !== 1'b1 || dmem_wr_en !== 1'b1 || dmem_wr_data !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL strb_fill got g=%b we=%b d=%h exp=1/1/ffffffff", m1_gnt, dmem_wr_en, dmem_wr_data);
    end
    @(posedge clk); #1;
    m1_wr_data = 32'h11223344; m1_strb = 4'h5;
    @(negedge clk);
    total++;
    if (dmem_strb !== 4'h5 || dmem_wr_en !== 1'b1) begin
      bad++; $display("FAIL strb_mux got strb=%h we=%b exp=5/1", dmem_strb, dmem_wr_en);
    end
    @(posedge clk); #1;
    m1_wr_en = 0;
    @(negedge clk);
    total++;
    if (dmem_wr_en !== 1'b0 || m1_gnt !== 1'b1) begin
      bad++; $display("FAIL strb_read_cycle got we=%b g=%b exp=0/1", dmem_wr_en, m1_gnt);
    end
    @(posedge clk); #1;
    m1_req = 0;
    @(negedge clk);
    total++;
    if (m1_rvalid !== 1'b1 || m1_rd_data !== 32'hFF22FF44) begin
      bad++; $display("FAIL strb_merge got v=%b d=%h exp=1/ff22ff44", m1_rvalid, m1_rd_data);
    end
    total++;
    if (dmem_wr_en !== 1'b0) begin
      bad++; $display("FAIL strb_drop_we got=%b exp=0", dmem_wr_en);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (dmem_wr_en !== 1'b0 || m1_gnt !== 1'b0) begin
      bad++; $display("FAIL strb_end got we=%b g=%b exp=0/0", dmem_wr_en, m1_gnt);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    m1_req = 1; m1_wr_en = 0; m1_addr = 32'hC0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++;
    if (m1_gnt !== 1'b1 || m1_rvalid !== 1'b1 || m1_rd_data !== 32'hFF22FF44) begin
      bad++; $display("FAIL rstmid_pre got g=%b v=%b d=%h exp=1/1/ff22ff44", m1_gnt, m1_rvalid, m1_rd_data);
    end
    #1;
    rstn = 0;
    #1;
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dmem_wr_en} !== 5'b0) begin
      bad++; $display("FAIL rstmid_ctrl got=%b exp=00000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dmem_wr_en});
    end
    total++;
    if (m1_rd_data !== 32'h0 || dmem_addr !== 32'h0 || dmem_strb !== 4'h0) begin
      bad++; $display("FAIL rstmid_data got d=%h addr=%h strb=%h exp=0", m1_rd_data, dmem_addr, dmem_strb);
    end
    @(posedge clk); #1;
    m0_req = 1; m0_wr_en = 0; m0_addr = 32'h10;
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      bad++; $display("FAIL rstmid_tie got=%b%b exp=10", m0_gnt, m1_gnt);
    end
    #1;
    idle_inputs();
    @(posedge clk); @(posedge clk);
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    test_reset();
    test_single();
    test_tie();
    test_burst_limit();
    test_back_to_back();
    test_strobe();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_arb.md
# riscv_dmem_arb

Two-port arbiter that shares the single-port data memory (`riscv_dmem`) between the CPU memory stage (port 0) and an external loader/debug master (port 1). It grants one owner at a time with round-robin fairness and a bounded burst length. It multiplexes the owner's address, write and strobe signals onto the memory. It returns registered read data with a valid pulse one cycle after each accepted read. It sits in `riscv_top` between `u_riscv_cpu` data-side outputs and `u_riscv_dmem`.

## Interface
- `XLEN`, 32, data/address width
- `BURST_MAX`, 8, max consecutive accepted beats for one owner while the other port is requesting (≥1)
- `i_clk`  in  1  clock; memory writes on rising edge
- `i_rstn`  in  1  asynchronous, active-low reset
- `i_mN_req`  in  1  port N (N=0,1) request; held stable with its command until granted
- `i_mN_addr`  in  XLEN  port N byte address
- `i_mN_wr_en`  in  1  port N write (1) / read (0)
- `i_mN_strb`  in  4  port N byte strobes
- `i_mN_wr_data`  in  XLEN  port N write data
- `o_mN_gnt`  out  1  port N owns memory this cycle; beat accepted when `i_mN_req & o_mN_gnt`
- `o_mN_rd_data`  out  XLEN  registered read data for port N
- `o_mN_rvalid`  out  1  one-cycle pulse: `o_mN_rd_data` valid
- `o_dmem_addr`  out  XLEN  memory address (owner's, else 0)
- `o_dmem_wr_en`  out  1  memory write enable
- `o_dmem_strb`  out  4  memory byte strobes
- `o_dmem_wr_data`  out  XLEN  memory write data
- `i_dmem_rd_data`  in  XLEN  memory combinational read data

## Operation
- FSM states: IDLE, OWN0, OWN1. Registers: `last` (last port served), `beats` (saturating counter, width clog2(BURST_MAX)+1), read-return registers per port.
- IDLE: no request → stay. Only one port requesting → OWNN. Both requesting → the port ≠ `last`.
- OWNN: `o_mN_gnt`=1 (combinational from state). Memory outputs are muxed from port N. `o_dmem_wr_en = i_mN_req & i_mN_wr_en`. If `i_mN_req`=0, memory outputs are all 0 except `o_dmem_addr`, which holds `i_mN_addr`.
- Each accepted beat increments `beats`.
- OWNN exit at edge:
  - if `i_mN_req`=0 → OWN(other) if other requests, else IDLE;
  - if the other port requests and `beats`==BURST_MAX after this beat → OWN(other).
  - Otherwise stay.
- On any exit: `last`←N and `beats`←0.
- With the other port idle, an owner may burst indefinitely; `beats` saturates at BURST_MAX.
- Accepted read (req, gnt, !wr_en): next edge latches `i_dmem_rd_data` into `o_mN_rd_data` and pulses `o_mN_rvalid` for 1 cycle. `o_mN_rd_data` holds until the next read return for that port.
- Writes produce no rvalid.
- Never both grants high. The non-owner's signals never reach memory.

## Timing
- Reset (async assert): state IDLE, `last`=1 (port 0 wins first tie), `beats`=0. All `o_*` outputs 0.
- Deassertion is synchronous to `i_clk` externally.
- Request-to-grant: 1 cycle from IDLE (req seen at edge k, gnt during cycle k+1). 0 cycles when the port already owns.
- Handover: the losing owner's last accepted beat is in cycle k and the new owner is granted in cycle k+1. No idle bubble when the other port is waiting.
- Throughput: 1 beat/cycle while owned.
- Read latency: rvalid 1 cycle after acceptance. Back-to-back reads give back-to-back rvalid pulses.
- Simultaneous events:
  - Owner drop and other request in the same cycle → immediate switch.
  - Both ports first requesting in IDLE → port ≠ `last`.
- Reset mid-burst: a write accepted at the edge coincident with reset assertion is not guaranteed. A pending rvalid is cleared. Arbitration restarts from IDLE with port 0 priority.

## Test plan
- Single port: m0 writes 0xDEADBEEF, strb 0xF, to 0x10, then reads 0x10 → gnt 1 cycle after req; `o_m0_rvalid` pulses 1 cycle after read acceptance with data 0xDEADBEEF; m1 gnt stays 0.
- Tie after reset: m0 and m1 both request in the same cycle → m0 granted first; after m0 drops, m1 granted the next cycle with no bubble.
- Burst limit: m0 holds req for 20 reads, m1 requests continuously, BURST_MAX=8 → m0 gets 8 beats, m1 gets 8, then m0 again; never both gnt high.
- Unloaded burst: m0 does 20 back-to-back reads with m1 idle → 20 consecutive gnt cycles and 20 consecutive rvalid pulses, each carrying the correct data.
- Byte strobes: m1 writes 0x11223344, strb 0x5, over 0xFFFFFFFF, then reads → 0xFF22FF44; `o_dmem_wr_en`=0 on every non-accepted cycle.
- Reset mid-burst: assert `i_rstn`=0 mid-cycle during an m1 burst → all outputs 0 immediately; after release, simultaneous requests grant m0 first.
